// File: rtl/mult_div_ctrl_if.sv
// Request/response bundle between the datapath and the MULT/DIV sequencer.
interface mult_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: shift-add multiplier and restoring divider,
// one iteration per clock, owning the HI/LO register pair.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;

  logic               is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, trial;
  logic [2*WIDTH-1:0] prod;

  // Raw operands sit in acc_lo/opb between launch and INIT.
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & acc_lo_q[WIDTH-1];
  assign b_neg     = is_signed & opb_q[WIDTH-1];
  assign a_mag     = a_neg ? -acc_lo_q : acc_lo_q;
  assign b_mag     = b_neg ? -opb_q : opb_q;

  assign add_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  assign trial   = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opb_q};
  assign prod    = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    case (state_q)
      // A start in the DONE cycle launches directly, so back-to-back ops lose no cycle.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        dz_d    = 1'b0;
        if (bus.start) begin
          state_d  = S_INIT;
          op_d     = bus.op;
          acc_lo_d = bus.a;
          opb_d    = bus.b;
        end
      end
      S_INIT: begin
        acc_hi_d = '0;
        acc_lo_d = is_div ? a_mag : b_mag;
        opb_d    = is_div ? b_mag : a_mag;
        neg_lo_d = a_neg ^ b_neg;
        neg_hi_d = a_neg;
        cnt_d    = '0;
        if (is_div && opb_q == '0) begin
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div) begin
          if (!trial[WIDTH]) begin
            acc_hi_d = trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = add_sum[WIDTH:1];
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div) begin
          lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = (state_q == S_DONE) && dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule
